message_assembler: RTL
======================

MESSAGE_ASSEMBLER -- requirements
Module: message_assembler

Interface
REQ-001 Parameter HEADER_WORDS, default 20, is the number of 32-bit payload words per message; the legal range is 1..29.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: the reset; asynchronous, active-high.
REQ-004 The block SHALL have the port in_word, input, 32 bits: the payload word.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: in_word is valid.
REQ-006 The block SHALL have the port in_last, input, 1 bit: the current word is the final payload word of the frame.
REQ-007 The block SHALL have the port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have the port message, output, 1024 bits: the padded two-block SHA-256 message; block 0 is bits [1023:512] and block 1 is bits [511:0].
REQ-009 The block SHALL have the port msg_valid, output, 1 bit: message is complete and held stable.
REQ-010 The block SHALL have the port msg_ready, input, 1 bit: the consumer takes message.
REQ-011 The block SHALL have the port err, output, 1 bit: a one-cycle pulse on a framing error.

Function
REQ-012 The block SHALL have two states: COLLECT and OUTPUT.
REQ-013 In COLLECT, in_ready SHALL be 1; in OUTPUT, in_ready SHALL be 0.
REQ-014 A word SHALL be accepted only when in_valid and in_ready are both 1.
REQ-015 When a word is accepted, it SHALL be stored in slot cnt, and cnt SHALL increment.
- cnt is a 5-bit internal word counter.
- Slot i SHALL occupy message[1023-32i : 992-32i].
REQ-016 Padding SHALL be constant and combinational:
- word HEADER_WORDS = 32'h80000000;
- words HEADER_WORDS+1..29 = 0;
- message[63:0] = HEADER_WORDS*32 as a 64-bit big-endian bit length (0x280 for the default).
REQ-017 Accepting a word with cnt==HEADER_WORDS-1 and in_last=1 SHALL cause the following:
- the state SHALL go to OUTPUT;
- msg_valid SHALL be 1 on the next cycle (one-cycle latency);
- cnt SHALL be cleared.
REQ-018 Accepting a word with in_last=1 and cnt<HEADER_WORDS-1 SHALL be a framing error:
- err SHALL pulse 1 for exactly one cycle;
- all slots SHALL be zeroed;
- cnt SHALL be cleared to 0;
- the state SHALL remain COLLECT.
REQ-019 Accepting a word with cnt==HEADER_WORDS-1 and in_last=0 SHALL be handled as a framing error, identical to REQ-018.
REQ-020 In OUTPUT, message and msg_valid SHALL hold stable until msg_ready=1; in_valid and in_last SHALL be ignored.
REQ-021 The cycle with msg_valid and msg_ready both 1 SHALL be the handoff:
- the next state SHALL be COLLECT, with msg_valid=0 and in_ready=1 on the next cycle;
- the slots are not cleared and SHALL be overwritten by the next frame.
REQ-022 msg_ready SHALL have no effect when msg_valid=0.
REQ-023 The value of message while msg_valid=0 SHALL be unspecified to consumers.
REQ-024 Sustained throughput SHALL be one message per HEADER_WORDS+1 cycles when in_valid=1 and msg_ready=1 continuously.

Reset
REQ-025 While rst=1, all of the following SHALL hold asynchronously:
- state=COLLECT and cnt=0;
- all slots=0;
- msg_valid=0, err=0, in_ready=0.
REQ-026 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-027 A reset asserted mid-frame or during OUTPUT SHALL discard the partial or held message without an err pulse.

Verification
REQ-028 The bench SHALL cover a nominal frame:
- stimulus: 20 words 0x00000001..0x00000014, in_last on the 20th, msg_ready=1;
- response: msg_valid on the next cycle; message[1023:992]=0x00000001; message[415:384]=0x00000014; message[383:352]=0x80000000; message[351:64]=0; message[63:0]=0x280.
REQ-029 The bench SHALL cover backpressure:
- stimulus: msg_ready held 0 for 5 cycles after msg_valid, with in_valid=1 throughout;
- response: message unchanged; in_ready=0; no words stored; handoff on the cycle msg_ready rises.
REQ-030 The bench SHALL cover an early in_last:
- stimulus: in_last on the 7th word;
- response: err=1 for one cycle; no msg_valid; a following correct 20-word frame assembles exactly as in REQ-028.
REQ-031 The bench SHALL cover a missing in_last:
- stimulus: 20 words with in_last=0;
- response: err pulse after the 20th word; cnt=0; no msg_valid.
REQ-032 The bench SHALL cover reset mid-frame:
- stimulus: rst pulsed after 10 words;
- response: msg_valid=0 and err=0; a fresh 20-word frame produces a correct message with no residue of the first 10 words.
REQ-033 The bench SHALL cover gaps and back-to-back frames:
- stimulus: in_valid toggling every cycle, then two back-to-back frames with msg_ready tied to 1;
- response: contents as in REQ-028; the second msg_valid follows 21 cycles after the first when in_valid is held at 1.

Source files
------------

// File: rtl/message_assembler.sv
// Collects HEADER_WORDS 32-bit words into a padded two-block SHA-256 message
// and holds it until the consumer takes it; bad framing drops the partial frame.
module message_assembler #(
    parameter int HEADER_WORDS = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   in_word,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [1023:0] message,
    output logic          msg_valid,
    input  logic          msg_ready,
    output logic          err
);

    typedef enum logic {COLLECT, OUTPUT} state_t;

    localparam logic [4:0] LAST_CNT = 5'(HEADER_WORDS - 1);

    state_t                         state_q, state_d;
    logic [4:0]                     cnt_q, cnt_d;
    logic [HEADER_WORDS-1:0][31:0]  slots_q, slots_d;
    logic                           err_q, err_d;
    logic                           accept;

    // Gated by rst so the port reads 0 for the whole reset window.
    assign in_ready  = (state_q == COLLECT) && !rst;
    assign msg_valid = (state_q == OUTPUT);
    assign err       = err_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slots_d = slots_q;
        err_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int i = 0; i < HEADER_WORDS; i++) begin
                        if (cnt_q == 5'(i)) slots_d[i] = in_word;
                    end
                    if (in_last && cnt_q == LAST_CNT) begin
                        state_d = OUTPUT;
                        cnt_d   = 5'd0;
                    end else if (in_last || cnt_q == LAST_CNT) begin
                        // Frame length disagrees with in_last: drop everything.
                        slots_d = '0;
                        cnt_d   = 5'd0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            OUTPUT: begin
                if (msg_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= 5'd0;
            slots_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
            err_q   <= err_d;
        end
    end

    // Payload words, then the 0x80 marker word, zero fill, 64-bit bit length.
    always_comb begin
        message = '0;
        for (int i = 0; i < HEADER_WORDS; i++) begin
            message[1023-32*i -: 32] = slots_q[i];
        end
        message[1023-32*HEADER_WORDS -: 32] = 32'h8000_0000;
        message[63:0] = 64'(HEADER_WORDS * 32);
    end

endmodule
